// File: rtl/move_link_pkg.sv
// Shared definitions for the inter-board move link: baud constants, receiver
// state encoding and the 2-of-3 vote helper used by the oversampling receiver.
package move_link_pkg;

  localparam int unsigned CLK_HZ        = 65_000_000;
  localparam int unsigned BAUD_RATE     = 9600;
  localparam int unsigned SAMP_PER_BIT  = 16;
  localparam int unsigned CLK_PER_SAMP  = CLK_HZ / BAUD_RATE / SAMP_PER_BIT;
  localparam int unsigned PKT_LEN       = 8;
  localparam int unsigned WAITING_COUNT = 65_000;

  // Oversample phases around the bit centre that feed the majority vote.
  localparam int unsigned VOTE_PHASE_LO  = 7;
  localparam int unsigned VOTE_PHASE_MID = 8;
  localparam int unsigned VOTE_PHASE_HI  = 9;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/samp_tick_gen.sv
// Oversample tick generator: one-cycle tick every CLK_PER_SAMP clocks,
// realigned by 'clear' so ticks are phase-locked to the detected start edge.
module samp_tick_gen #(
  parameter int unsigned CLK_PER_SAMP = 423
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_PER_SAMP - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || (cnt_q == TERM)) begin
      cnt_d = '0;
    end
  end

  // 'reset' is active-low, matching the rest of the receiver.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == TERM) && !clear;

endmodule

// File: rtl/move_uart_rx.sv
// Move-link serial receiver: 16x oversampled, 2-of-3 voted UART frame decoder
// with an idle guard after reset or a framing error.
module move_uart_rx #(
  parameter int unsigned CLK_PER_SAMP  = move_link_pkg::CLK_PER_SAMP,
  parameter int unsigned SAMP_PER_BIT  = move_link_pkg::SAMP_PER_BIT,
  parameter int unsigned PKT_LEN       = move_link_pkg::PKT_LEN,
  parameter int unsigned WAITING_COUNT = move_link_pkg::WAITING_COUNT
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               rx,
  output logic               ready,
  output logic [PKT_LEN-1:0] data_out,
  output logic               frame_err
);

  import move_link_pkg::*;

  localparam int unsigned PW = (SAMP_PER_BIT > 1) ? $clog2(SAMP_PER_BIT) : 1;
  localparam int unsigned BW = $clog2(PKT_LEN + 2);
  localparam int unsigned IW = $clog2(WAITING_COUNT + 1);

  localparam logic [PW-1:0] LAST_PHASE = PW'(SAMP_PER_BIT - 1);
  localparam logic [PW-1:0] PH_LO      = PW'(VOTE_PHASE_LO);
  localparam logic [PW-1:0] PH_MID     = PW'(VOTE_PHASE_MID);
  localparam logic [PW-1:0] PH_HI      = PW'(VOTE_PHASE_HI);
  localparam logic [BW-1:0] LAST_DATA  = BW'(PKT_LEN);
  localparam logic [IW-1:0] GUARD_LAST = IW'(WAITING_COUNT - 1);

  logic               sync1_q, rxs_q;
  rx_state_e          state_q, state_d;
  logic [IW-1:0]      idle_cnt_q, idle_cnt_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic [BW-1:0]      bit_idx_q, bit_idx_d;
  logic               samp_lo_q, samp_lo_d;
  logic               samp_mid_q, samp_mid_d;
  logic [PKT_LEN-1:0] shift_q, shift_d;
  logic [PKT_LEN-1:0] data_q, data_d;
  logic               ready_q, ready_d;
  logic               ferr_q, ferr_d;
  logic               tick, clear_tick, vote, mid_bit;

  samp_tick_gen #(
    .CLK_PER_SAMP(CLK_PER_SAMP)
  ) u_tick (
    .clk  (clk_in),
    .reset(rst_n_in),
    .clear(clear_tick),
    .tick (tick)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    phase_d    = phase_q;
    bit_idx_d  = bit_idx_q;
    samp_lo_d  = samp_lo_q;
    samp_mid_d = samp_mid_q;
    shift_d    = shift_q;
    data_d     = data_q;
    ready_d    = 1'b0;
    ferr_d     = 1'b0;
    clear_tick = 1'b0;
    vote       = majority3(samp_lo_q, samp_mid_q, rxs_q);
    mid_bit    = tick && (phase_q == PH_HI);

    if (tick) begin
      if (phase_q == LAST_PHASE) begin
        phase_d   = '0;
        bit_idx_d = bit_idx_q + BW'(1);
      end else begin
        phase_d = phase_q + PW'(1);
      end
      if (phase_q == PH_LO) begin
        samp_lo_d = rxs_q;
      end
      if (phase_q == PH_MID) begin
        samp_mid_d = rxs_q;
      end
    end

    unique case (state_q)
      WAIT_IDLE: begin
        if (!rxs_q) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == GUARD_LAST) begin
          idle_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      IDLE: begin
        if (!rxs_q) begin
          state_d    = START;
          clear_tick = 1'b1;
          phase_d    = '0;
          bit_idx_d  = '0;
        end
      end
      START: begin
        if (mid_bit) begin
          state_d = vote ? IDLE : DATA;
        end
      end
      DATA: begin
        if (mid_bit) begin
          shift_d = {vote, shift_q[PKT_LEN-1:1]};
          if (bit_idx_q == LAST_DATA) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        // Leaving at the stop-bit centre leaves half a bit to catch the next start edge.
        if (mid_bit) begin
          if (vote) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      default: begin
        state_d = WAIT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= WAIT_IDLE;
      idle_cnt_q <= '0;
      phase_q    <= '0;
      bit_idx_q  <= '0;
      samp_lo_q  <= 1'b1;
      samp_mid_q <= 1'b1;
      shift_q    <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      phase_q    <= phase_d;
      bit_idx_q  <= bit_idx_d;
      samp_lo_q  <= samp_lo_d;
      samp_mid_q <= samp_mid_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      ferr_q     <= ferr_d;
    end
  end

  assign ready     = ready_q;
  assign frame_err = ferr_q;
  assign data_out  = data_q;

endmodule
